// File: rtl/router_pkg.sv
// Shared router types and default widths used by fifo_4x64, the input stage and
// the output serializer.
package router_pkg;

  localparam int ROUTER_WORD_W = 64;
  localparam int ROUTER_LINK_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } router_tx_state_e;

  // Width of a beat counter for a given beats-per-word ratio (never zero bits).
  function automatic int router_cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/even_parity.sv
// Even-parity generator: parity is 1 when data holds an odd number of ones.
// Only compiled when ROUTER_TX_PARITY_EN is defined.
`ifdef ROUTER_TX_PARITY_EN
module even_parity #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule
`endif

// File: rtl/router_tx_serializer.sv
// Router output stage: pops FIFO words and sends them as RATIO link beats, LSB slice first.
// Optional ROUTER_TX_PARITY_EN adds an even-parity bit per beat on tx_parity.
module router_tx_serializer
  import router_pkg::*;
#(
  parameter int IN_WIDTH  = ROUTER_WORD_W,
  parameter int OUT_WIDTH = ROUTER_LINK_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [OUT_WIDTH-1:0] tx_data,
  output logic                 tx_last
`ifdef ROUTER_TX_PARITY_EN
  ,
  output logic                 tx_parity
`endif
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = router_cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_SLICE     = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_SLICE = CNT_W'(RATIO - 2);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
    $error("router_tx_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  router_tx_state_e     state;
  logic [IN_WIDTH-1:0]  word_q;
  logic [CNT_W-1:0]     slice_cnt;
  logic                 tx_valid_reg;
  logic                 tx_last_reg;
  logic                 beat_xfer;
  logic [OUT_WIDTH-1:0] slices [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slices[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign beat_xfer = tx_valid_reg && tx_ready;

  // The pop must reach the FIFO in the same cycle it is decided, so it is the
  // one combinational output; it is forced low while reset is asserted.
  always_comb begin
    fifo_pop = 1'b0;
    if (!reset && !fifo_empty) begin
      unique case (state)
        IDLE:    fifo_pop = 1'b1;
        SEND:    fifo_pop = beat_xfer && tx_last_reg;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_q       <= '0;
      slice_cnt    <= '0;
      tx_valid_reg <= 1'b0;
      tx_last_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          word_q       <= fifo_rd_data;
          slice_cnt    <= '0;
          tx_valid_reg <= 1'b1;
          tx_last_reg  <= (RATIO == 1);
          state        <= SEND;
        end
        SEND: begin
          if (beat_xfer) begin
            if (tx_last_reg) begin
              tx_valid_reg <= 1'b0;
              tx_last_reg  <= 1'b0;
              state        <= fifo_pop ? FETCH : IDLE;
            end else begin
              slice_cnt   <= slice_cnt + 1'b1;
              tx_last_reg <= (slice_cnt == PRE_LAST_SLICE);
            end
          end
        end
        default: begin
          state        <= IDLE;
          tx_valid_reg <= 1'b0;
          tx_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  // tx_last_reg mirrors slice_cnt == LAST_SLICE while a beat is presented.
  assign tx_valid = tx_valid_reg;
  assign tx_last  = tx_last_reg && (slice_cnt == LAST_SLICE);
  assign tx_data  = tx_valid_reg ? slices[slice_cnt] : '0;

`ifdef ROUTER_TX_PARITY_EN
  logic beat_parity;

  even_parity #(.WIDTH(OUT_WIDTH)) u_even_parity (
    .data   (tx_data),
    .parity (beat_parity)
  );

  assign tx_parity = tx_valid_reg & beat_parity;
`else
  // Without the parity option the link carries no check bit.
`endif

endmodule
